mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencing controller that computes an OPW x OPW unsigned product with a single shared 4x4 combinational array multiplier.
- Splits each operand into 4-bit digits and feeds one digit pair per cycle to the multiplier.
- Shifts and accumulates the partial products into a 2*OPW result.
- Sits between a requester using a valid/ready handshake and a consumer using a valid/ready handshake; trades latency for area.

Parameters:
- OPW, 8, operand width in bits; must be a multiple of 4 and at least 4.
- D (derived localparam), OPW/4, digits per operand. Steps per product = D*D.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- a  input  OPW  multiplicand, sampled on input handshake.
- b  input  OPW  multiplier, sampled on input handshake.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*OPW  result; held stable while out_valid=1.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; in_ready=1 (combinational from IDLE); out_valid=0; busy=0; product=0; step=0; operand registers=0.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch a and b, clear acc, set step=0, go to CALC.
  - CALC: in_ready=0. Each cycle: i = step mod D (digit of a), j = step div D (digit of b); pp = a_dig[i] * b_dig[j] (8 bits, from the 4x4 multiplier); acc += pp << 4*(i+j). acc is 2*OPW wide; no overflow is possible. If step = D*D-1, go to DONE; otherwise step++.
  - DONE: out_valid=1, product=acc. On out_ready=1, go to IDLE. out_valid drops on the next cycle.
- Latency: out_valid rises exactly D*D edges after the accepting edge (4 for OPW=8).
- Throughput: one product per D*D+2 cycles when out_ready is held high. in_ready is never high in DONE; no overlap between requests.
- Inputs a and b are ignored except on the input handshake; changes during CALC have no effect.
- out_ready while not in DONE is ignored.
- in_valid while not in IDLE is ignored; the requester holds the request.
- rst mid-CALC or mid-DONE: the in-flight result is discarded and all outputs return to reset values on that edge.
- Simultaneous in_valid and rst: rst wins; nothing is latched.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: on the input handshake, if a==0 or b==0, go directly from IDLE to DONE with acc=0. out_valid rises 1 edge after the accepting edge. All other requests behave as without the macro.
- Undefined: every request takes D*D CALC cycles regardless of operand values.

Decomposition:
- Package mul_ctrl_pkg:
  - state typedef (IDLE, CALC, DONE), 2-bit encoding.
  - DIGIT_W=4.
  - PP_W=8.
- One sub-module: the existing array_mul_4, instantiated once. Its inputs are the two muxed digits; its output is the 8-bit pp.
- The digit mux, shifter, accumulator and FSM are in mul_seq_ctrl.

Test Plan:
- OPW=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid high 4 cycles after accept, product=0xFE01, returns to IDLE next cycle.
- a=0x12, b=0x34, then a=0x0F, b=0xF0 back-to-back with in_valid held high -> products 0x03A8 then 0x0E10; in_ready low throughout each CALC/DONE; second accept occurs the cycle after the first output handshake.
- a=0xA5, b=0x3C, out_ready=0 for 3 cycles after out_valid -> product=0x26AC and out_valid held stable; in_ready=0; handshake on cycle 4 returns to IDLE.
- rst=1 asserted at CALC step 2 -> next cycle state=IDLE, out_valid=0, product=0, in_ready=1. A fresh request 0x02*0x03 then yields 0x0006.
- a=0x00, b=0xAB -> product=0x0000. Latency 4 without MUL_ZERO_SKIP_EN, 1 with it.
- OPW=12, a=0xFFF, b=0xFFF -> product=0xFFE001 after 9 CALC cycles.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_ctrl_pkg
// Shared types and constants for the digit-serial multiplier controller.
//   state_t  : controller FSM states (2-bit encoding)
//   DIGIT_W  : width of one operand digit fed to the shared multiplier
//   PP_W     : width of one partial product from the 4x4 multiplier
// -----------------------------------------------------------------------------
package mul_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam int PP_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/array_mul_4.sv
// -----------------------------------------------------------------------------
// array_mul_4
// Combinational 4x4 unsigned array multiplier (shift-and-add rows).
// Ports:
//   x  input  [3:0]  first digit
//   y  input  [3:0]  second digit
//   p  output [7:0]  x * y
// -----------------------------------------------------------------------------
module array_mul_4
    import mul_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [PP_W-1:0]    p
);

    logic [PP_W-1:0] sum_s;
    logic [PP_W-1:0] x_ext_s;

    // One AND-row per bit of y, each shifted by its bit position and summed.
    always_comb begin
        x_ext_s = {4'd0, x};
        sum_s   = 8'd0;
        for (int k = 0; k < DIGIT_W; k++) begin
            if (y[k]) begin
                sum_s = sum_s + (x_ext_s << k);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign p = sum_s;

endmodule

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Digit-serial unsigned multiplier: OPW x OPW product built from D*D passes
// through one shared 4x4 array multiplier, with valid/ready on both sides.
// Parameters:
//   OPW  operand width (multiple of 4, >= 4); D = OPW/4 digits per operand
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request valid          in_ready   controller idle, can accept
//   a, b       operands, sampled on the input handshake
//   out_valid  product valid          out_ready  consumer accepts product
//   product    2*OPW result, stable while out_valid=1
//   busy       high while calculating or holding a result
// Optional build macro:
//   MUL_ZERO_SKIP_EN  requests with a zero operand finish after one cycle
// -----------------------------------------------------------------------------
module mul_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int OPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*OPW-1:0] product,
    output logic             busy
);

    localparam int D     = OPW / DIGIT_W;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam int PW    = 2 * OPW;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

    state_t           state_r;
    state_t           state_s;
    logic [OPW-1:0]   a_r;
    logic [OPW-1:0]   b_r;
    logic [PW-1:0]    acc_r;
    // step is kept as (i_r, j_r) = (step mod D, step div D)
    logic [IDX_W-1:0] i_r;
    logic [IDX_W-1:0] j_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [DIGIT_W-1:0] a_dig_s;
    logic [DIGIT_W-1:0] b_dig_s;
    logic [PP_W-1:0]    pp_s;
    logic [PW-1:0]      pp_wide_s;
    logic [PW-1:0]      pp_shift_s;
    logic               last_step_s;
    logic               zero_req_s;

    // Digit select for the current step and the weighted partial product.
    always_comb begin
        a_dig_s     = a_r[int'(i_r)*DIGIT_W +: DIGIT_W];
        b_dig_s     = b_r[int'(j_r)*DIGIT_W +: DIGIT_W];
        last_step_s = (i_r == LAST_IDX) && (j_r == LAST_IDX);
        pp_wide_s   = '0;
        pp_wide_s[PP_W-1:0] = pp_s;
        pp_shift_s  = pp_wide_s << (DIGIT_W * (int'(i_r) + int'(j_r)));
    end

    array_mul_4 u_mul (
        .x (a_dig_s),
        .y (b_dig_s),
        .p (pp_s)
    );

    // Zero-operand detection on the incoming request.
    always_comb begin
`ifdef MUL_ZERO_SKIP_EN
        zero_req_s = (a == '0) || (b == '0);
`else
        zero_req_s = 1'b0;
`endif
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_step_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand, step and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            i_r         <= '0;
            j_r         <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc_r <= '0;
                        // A zero operand makes every partial product zero, so
                        // jumping to the final step yields acc=0 after one cycle.
                        if (zero_req_s) begin
                            i_r <= LAST_IDX;
                            j_r <= LAST_IDX;
                        end else begin
                            i_r <= '0;
                            j_r <= '0;
                        end
                    end else begin
                        a_r <= a_r;
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_r + pp_shift_s;
                    if (last_step_s) begin
                        i_r <= i_r;
                    end else if (i_r == LAST_IDX) begin
                        i_r <= '0;
                        j_r <= j_r + IDX_W'(1);
                    end else begin
                        i_r <= i_r + IDX_W'(1);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = acc_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    logic        in_valid12;
    logic        in_ready12;
    logic [11:0] a12;
    logic [11:0] b12;
    logic        out_valid12;
    logic        out_ready12;
    logic [23:0] product12;
    logic        busy12;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.OPW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    mul_seq_ctrl #(.OPW(12)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
        .a(a12), .b(b12), .out_valid(out_valid12), .out_ready(out_ready12),
        .product(product12), .busy(busy12)
    );

    // Expected latency for a request under the current build.
    function automatic int exp_latency(input logic [7:0] xa, input logic [7:0] xb);
`ifdef MUL_ZERO_SKIP_EN
        if (xa == 8'd0 || xb == 8'd0) return 1;
`endif
        return 4;
    endfunction

    // Issue one request on the 8-bit DUT and collect what the consumer sees.
    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_req(input logic [7:0] ra, input logic [7:0] rb, input int stall,
                           output logic [15:0] prod, output int lat,
                           output bit stable, output bit timeout);
        int guard;
        prod = 16'd0; lat = 0; stable = 1'b1; timeout = 1'b0;
        a = ra; b = rb; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; lat++; guard++;
        end
        if (guard >= 100) timeout = 1'b1;
        prod = product;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || product !== prod || in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) stable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0;
        in_valid12 = 1'b0; out_ready12 = 1'b0; a12 = 12'd0; b12 = 12'd0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (product !== 16'h0000) begin failures++; $display("FAIL reset_product got=%h exp=0000", product); end
    endtask

    task automatic test_max();
        logic [15:0] p; int lat; bit st; bit to;
        run_req(8'hFF, 8'hFF, 0, p, lat, st, to);
        checks++; if (to) begin failures++; $display("FAIL max_timeout got=timeout exp=out_valid"); end
        checks++; if (p !== 16'hFE01) begin failures++; $display("FAIL max_product got=%h exp=fe01", p); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL max_latency got=%0d exp=4", lat); end
        checks++; if (!st) begin failures++; $display("FAIL max_return_idle got=bad exp=idle"); end
    endtask

    task automatic test_back_to_back();
        logic exp_ready, exp_valid;
        logic [15:0] exp_p;
        a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin a = 8'h0F; b = 8'hF0; end
            if (cyc == 6) in_valid = 1'b0;
            exp_ready = (cyc == 5) || (cyc == 11);
            exp_valid = (cyc == 4) || (cyc == 10);
            exp_p     = (cyc < 6) ? 16'(8'h12) * 16'(8'h34) : 16'(8'h0F) * 16'(8'hF0);
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
            checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (product !== exp_p) begin failures++; $display("FAIL b2b_product cyc=%0d got=%h exp=%h", cyc, product, exp_p); end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [15:0] p; int lat; bit st; bit to;
        run_req(8'hA5, 8'h3C, 3, p, lat, st, to);
        checks++; if (to) begin failures++; $display("FAIL stall_timeout got=timeout exp=out_valid"); end
        checks++; if (p !== 16'h26AC) begin failures++; $display("FAIL stall_product got=%h exp=26ac", p); end
        checks++; if (!st) begin failures++; $display("FAIL stall_hold got=unstable exp=stable"); end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] p; int lat; bit st; bit to;
        a = 8'h55; b = 8'h66; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (product !== 16'h0000) begin failures++; $display("FAIL midrst_product got=%h exp=0000", product); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        run_req(8'h02, 8'h03, 0, p, lat, st, to);
        checks++; if (p !== 16'h0006 || to) begin failures++; $display("FAIL midrst_fresh got=%h exp=0006", p); end
    endtask

    task automatic test_rst_with_valid();
        rst = 1'b1; in_valid = 1'b1; a = 8'h05; b = 8'h07;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstvalid_latched got=busy%b exp=idle", busy); end
        checks++; if (product !== 16'h0000) begin failures++; $display("FAIL rstvalid_product got=%h exp=0000", product); end
    endtask

    task automatic test_zero();
        logic [15:0] p; int lat; bit st; bit to;
        run_req(8'h00, 8'hAB, 0, p, lat, st, to);
        checks++; if (p !== 16'h0000 || to) begin failures++; $display("FAIL zero_a_product got=%h exp=0000", p); end
        checks++; if (lat !== exp_latency(8'h00, 8'hAB)) begin failures++; $display("FAIL zero_a_latency got=%0d exp=%0d", lat, exp_latency(8'h00, 8'hAB)); end
        run_req(8'h9C, 8'h00, 1, p, lat, st, to);
        checks++; if (p !== 16'h0000 || !st || to) begin failures++; $display("FAIL zero_b_product got=%h exp=0000", p); end
        checks++; if (lat !== exp_latency(8'h9C, 8'h00)) begin failures++; $display("FAIL zero_b_latency got=%0d exp=%0d", lat, exp_latency(8'h9C, 8'h00)); end
    endtask

    task automatic test_random();
        logic [15:0] p; int lat; bit st; bit to;
        logic [7:0] ra, rb;
        logic [15:0] exp_p;
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            exp_p = 16'(ra) * 16'(rb);
            run_req(ra, rb, int'($urandom_range(0, 2)), p, lat, st, to);
            checks++;
            if (p !== exp_p || lat !== exp_latency(ra, rb) || !st || to) begin
                failures++;
                $display("FAIL rand_%0d a=%h b=%h got=%h lat=%0d stable=%0b exp=%h lat=%0d", n, ra, rb, p, lat, st, exp_p, exp_latency(ra, rb));
            end
        end
    endtask

    task automatic test_opw12();
        int lat;
        a12 = 12'hFFF; b12 = 12'hFFF; in_valid12 = 1'b1; out_ready12 = 1'b0;
        @(posedge clk); #1;
        in_valid12 = 1'b0; a12 = 12'h123; b12 = 12'h456;
        lat = 0;
        while (out_valid12 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat !== 9) begin failures++; $display("FAIL opw12_latency got=%0d exp=9", lat); end
        checks++; if (product12 !== 24'hFFE001) begin failures++; $display("FAIL opw12_product got=%h exp=ffe001", product12); end
        checks++; if (in_ready12 !== 1'b0 || busy12 !== 1'b1) begin failures++; $display("FAIL opw12_busy got=%b exp=1", busy12); end
        out_ready12 = 1'b1;
        @(posedge clk); #1;
        out_ready12 = 1'b0;
        checks++; if (out_valid12 !== 1'b0 || in_ready12 !== 1'b1) begin failures++; $display("FAIL opw12_idle got=%b exp=1", in_ready12); end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_stall();
        test_reset_mid_calc();
        test_rst_with_valid();
        test_zero();
        test_random();
        test_opw12();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
